axil_master: RTL

Single-outstanding AXI4-Lite initiator that turns simple command-port requests into AXI-Lite write and read transactions. It sits on the host side of the subsystem interconnect, driving the AXI-Lite slave front-end of the register block. It returns each completion (read data and response code) on a response port. A timeout counter detects hung slaves so the host can recover.

---
 rtl/axil_master.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_master.sv
// rtl/axil_master.sv - single-outstanding AXI4-Lite initiator driven by a command/response port
//
// Purpose:
//   Turns one host command at a time into an AXI4-Lite write (AW+W, then B) or
//   read (AR, then R) and returns the completion on the response port. A
//   per-transaction timeout aborts a hung slave and reports SLVERR with
//   rsp_timeout set.
//
// Ports:
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (cmd_ready is high only in IDLE)
//   cmd_write/addr/wdata/wstrb     command fields, registered on accept
//   rsp_valid/rsp_ready            completion handshake
//   rsp_rdata/rsp_resp/rsp_timeout completion fields, held stable while rsp_valid
//   m_aw*, m_w*, m_b*              AXI4-Lite write address, data and response channels
//   m_ar*, m_r*                    AXI4-Lite read address and data channels

module axil_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [2:0]        m_awprot,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [2:0]        m_arprot,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    // A zero-width counter is not legal, so TIMEOUT=0 keeps a 1-bit counter
    // that is simply never compared.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RSP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic busy;
    logic expire;
    logic completion;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;

        busy = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
               (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);
        // bready/rready are registered high throughout their response states,
        // so the slave valid alone marks the completing handshake.
        completion = ((state_q == ST_WR_RESP) && m_bvalid) ||
                     ((state_q == ST_RD_RESP) && m_rvalid);
        expire = (TIMEOUT > 0) && busy && (cnt_q == CNT_LAST);

        if (busy) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cnt_d = '0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently; move on once neither is pending.
                awvalid_d = awvalid_q && !m_awready;
                wvalid_d  = wvalid_q && !m_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (m_bvalid) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = m_bresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (m_rvalid) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = m_rdata;
                    rsp_resp_d    = m_rresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort: a real completion in the expiry cycle takes precedence.
        if (expire && !completion) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
            state_d       = ST_RSP;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;
    assign m_awaddr    = awaddr_q;
    assign m_awvalid   = awvalid_q;
    assign m_awprot    = 3'b000;
    assign m_wdata     = wdata_q;
    assign m_wstrb     = wstrb_q;
    assign m_wvalid    = wvalid_q;
    assign m_bready    = bready_q;
    assign m_araddr    = araddr_q;
    assign m_arvalid   = arvalid_q;
    assign m_arprot    = 3'b000;
    assign m_rready    = rready_q;

endmodule
